// File: rtl/uart_tx_pkg.sv
// Shared definitions for the 16-bit word UART transmitter.
// Holds the FSM state encoding, byte-select constants and frame-length helpers.
// Frame helpers are arithmetic only; the RTL does not depend on them.
package uart_tx_pkg;

   // Word transmitter states; WGAP is only reachable with UART_TX_WORD_GAP_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_GAP   = 3'd4,
      ST_WGAP  = 3'd5,
      ST_DONE  = 3'd6
   } tx_state_t;

   // The high byte always goes first on the line
   localparam logic BYTE_HI = 1'b0;
   localparam logic BYTE_LO = 1'b1;

   // Bit times in one byte frame: start + 8 data + stop
   localparam int FRAME_BITS = 10;

   // Clock cycles taken by one byte frame including its trailing gap bits
   function automatic int frame_cycles(input int clks_per_bit, input int gap_bits);
      return (FRAME_BITS + gap_bits) * clks_per_bit;
   endfunction

   // Clock cycles from accept edge to the Done pulse (inclusive of the Done cycle)
   function automatic int word_cycles(input int clks_per_bit, input int gap_bits,
                                      input int word_gap_bits);
      return 2 * frame_cycles(clks_per_bit, gap_bits)
             + word_gap_bits * clks_per_bit + 1;
   endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period divider for the UART transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
// load_i restarts the count so a new frame begins on a clean bit boundary.
module uart_tx_bit_timer #(
   parameter int CLKS_PER_BIT = 104
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic en_i,
   output logic bit_tick_o
);

   localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);

   logic [15:0] cnt_q;
   logic [15:0] cnt_d;

   // Tick marks the final cycle of the current bit; the FSM advances on it
   assign bit_tick_o = en_i && (cnt_q == LAST_CNT);

   // Next count: restart on load, wrap at the end of a bit, hold when idle
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end
   end

   // Counter register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx_word.sv
// 16-bit word UART transmitter: two 8N1 frames, high byte first, GAP_BITS idle after each.
// Latency: start bit appears the cycle after accept; Done pulses after both frames (+WGAP).
// No queuing: i_Tx_DV is ignored unless o_Tx_Ready. Optional macro UART_TX_WORD_GAP_EN adds WGAP.
module uart_tx_word
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 104,
   parameter int GAP_BITS     = 1
`ifdef UART_TX_WORD_GAP_EN
   ,
   parameter int WORD_GAP_BITS = 20
`endif
) (
   input  logic        i_Clock,
   input  logic        i_Reset,
   input  logic        i_Tx_DV,
   input  logic [15:0] i_Tx_Word,
   output logic        o_Tx_Ready,
   output logic        o_Tx_Active,
   output logic        o_Tx_Serial,
   output logic        o_Tx_Done
);

   // Reject illegal configurations at elaboration
   if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_cpb
      $error("uart_tx_word: CLKS_PER_BIT out of range 4..65535");
   end
   if (GAP_BITS < 1 || GAP_BITS > 15) begin : g_bad_gap
      $error("uart_tx_word: GAP_BITS out of range 1..15");
   end
`ifdef UART_TX_WORD_GAP_EN
   if (WORD_GAP_BITS < 1 || WORD_GAP_BITS > 65535) begin : g_bad_wgap
      $error("uart_tx_word: WORD_GAP_BITS out of range 1..65535");
   end
   localparam logic [15:0] LAST_WGAP = 16'(WORD_GAP_BITS - 1);
`endif

   localparam logic [3:0] LAST_GAP = 4'(GAP_BITS - 1);

   tx_state_t   state_q;
   logic [15:0] shadow_q;
   logic        byte_sel_q;
   logic [2:0]  bit_idx_q;
   logic [3:0]  gap_cnt_q;
`ifdef UART_TX_WORD_GAP_EN
   logic [15:0] wgap_cnt_q;
`endif
   logic        serial_q;
   logic        ready_q;
   logic        active_q;
   logic        done_q;

   logic        accept;
   logic        timer_en;
   logic        bit_tick;
   logic [7:0]  cur_byte;
   logic [2:0]  bit_idx_nxt;

   assign accept      = i_Tx_DV && ready_q;
   assign timer_en    = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign cur_byte    = (byte_sel_q == BYTE_HI) ? shadow_q[15:8] : shadow_q[7:0];
   assign bit_idx_nxt = bit_idx_q + 3'd1;

   uart_tx_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_timer (
      .clk_i     (i_Clock),
      .rst_i     (i_Reset),
      .load_i    (accept),
      .en_i      (timer_en),
      .bit_tick_o(bit_tick)
   );

   // Word FSM: sequences both frames and registers every line/status output
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q    <= ST_IDLE;
         shadow_q   <= '0;
         byte_sel_q <= BYTE_HI;
         bit_idx_q  <= '0;
         gap_cnt_q  <= '0;
`ifdef UART_TX_WORD_GAP_EN
         wgap_cnt_q <= '0;
`endif
         serial_q   <= 1'b1;
         ready_q    <= 1'b1;
         active_q   <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  shadow_q   <= i_Tx_Word;
                  byte_sel_q <= BYTE_HI;
                  state_q    <= ST_START;
                  serial_q   <= 1'b0;
                  ready_q    <= 1'b0;
                  active_q   <= 1'b1;
               end
            end

            ST_START: begin
               if (bit_tick) begin
                  state_q   <= ST_DATA;
                  bit_idx_q <= '0;
                  serial_q  <= cur_byte[0];
               end
            end

            ST_DATA: begin
               if (bit_tick) begin
                  if (bit_idx_q == 3'd7) begin
                     state_q  <= ST_STOP;
                     serial_q <= 1'b1;
                  end else begin
                     bit_idx_q <= bit_idx_nxt;
                     serial_q  <= cur_byte[bit_idx_nxt];
                  end
               end
            end

            ST_STOP: begin
               if (bit_tick) begin
                  state_q   <= ST_GAP;
                  gap_cnt_q <= '0;
               end
            end

            ST_GAP: begin
               if (bit_tick) begin
                  if (gap_cnt_q == LAST_GAP) begin
                     if (byte_sel_q == BYTE_HI) begin
                        // Second frame reuses START with the low byte selected
                        byte_sel_q <= BYTE_LO;
                        state_q    <= ST_START;
                        serial_q   <= 1'b0;
                     end else begin
`ifdef UART_TX_WORD_GAP_EN
                        state_q    <= ST_WGAP;
                        wgap_cnt_q <= '0;
`else
                        state_q  <= ST_DONE;
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
`endif
                     end
                  end else begin
                     gap_cnt_q <= gap_cnt_q + 4'd1;
                  end
               end
            end

`ifdef UART_TX_WORD_GAP_EN
            ST_WGAP: begin
               // Long idle window so the far-end receiver can resynchronise
               if (bit_tick) begin
                  if (wgap_cnt_q == LAST_WGAP) begin
                     state_q  <= ST_DONE;
                     active_q <= 1'b0;
                     done_q   <= 1'b1;
                  end else begin
                     wgap_cnt_q <= wgap_cnt_q + 16'd1;
                  end
               end
            end
`endif

            ST_DONE: begin
               done_q  <= 1'b0;
               ready_q <= 1'b1;
               state_q <= ST_IDLE;
            end

            default: begin
               state_q  <= ST_IDLE;
               serial_q <= 1'b1;
               ready_q  <= 1'b1;
               active_q <= 1'b0;
               done_q   <= 1'b0;
            end
         endcase
      end
   end

   assign o_Tx_Ready  = ready_q;
   assign o_Tx_Active = active_q;
   assign o_Tx_Serial = serial_q;
   assign o_Tx_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_word.sv
// Scoreboard bench for uart_tx_word: random and directed words, per-cycle line model,
// mid-bit sampling receiver, busy rejection, back-to-back and asynchronous reset.
// Optional macro UART_TX_WORD_GAP_EN exercises the word gap.
module tb_uart_tx_word;

   localparam int CPB = 4;
   localparam int GAP = 1;
`ifdef UART_TX_WORD_GAP_EN
   localparam int WG = 20;
`else
   localparam int WG = 0;
`endif
   localparam int FB     = 10 + GAP;              // bit times per byte frame
   localparam int DONE_K = 2 * FB * CPB + WG * CPB + 1;

   typedef struct {
      logic [15:0] w;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        dv;
   logic [15:0] word;
   logic        ready, active, serial, done;

   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   last_done_cyc = 0;
   int   last_acc = 0;
   exp_t exp_q[$];
   exp_t cur;
   logic busy = 1'b0;
   int   k, b, j, pos;
   logic [7:0] rx_hi, rx_lo;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_word #(
      .CLKS_PER_BIT(CPB),
      .GAP_BITS    (GAP)
`ifdef UART_TX_WORD_GAP_EN
      ,
      .WORD_GAP_BITS(WG)
`endif
   ) dut (
      .i_Clock    (clk),
      .i_Reset    (rst),
      .i_Tx_DV    (dv),
      .i_Tx_Word  (word),
      .o_Tx_Ready (ready),
      .o_Tx_Active(active),
      .o_Tx_Serial(serial),
      .o_Tx_Done  (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Expected line level k cycles after the accept edge (k=1 is the first start-bit cycle)
   function automatic logic exp_line(input logic [15:0] w, input int kk);
      int bb, jj, pp;
      logic [7:0] by;
      bb = (kk - 1) / CPB;
      jj = bb / FB;
      pp = bb % FB;
      if (jj >= 2) return 1'b1;
      by = (jj == 0) ? w[15:8] : w[7:0];
      if (pp == 0) return 1'b0;
      if (pp <= 8) return by[pp-1];
      return 1'b1;
   endfunction

   // Monitor: pops the expected word when its transmission begins and checks every cycle
   always @(negedge clk) begin
      if (rst) begin
         busy = 1'b0;
      end else begin
         if (!busy && exp_q.size() > 0 && cyc >= exp_q[0].acc) begin
            cur   = exp_q.pop_front();
            busy  = 1'b1;
            rx_hi = 8'h00;
            rx_lo = 8'h00;
         end
         if (busy) begin
            k = cyc - cur.acc + 1;
            if (k < DONE_K) begin
               chk("line", {31'd0, serial}, {31'd0, exp_line(cur.w, k)});
               chk("active_busy", {31'd0, active}, 32'd1);
               chk("ready_busy", {31'd0, ready}, 32'd0);
               chk("done_early", {31'd0, done}, 32'd0);
               if ((k - 1) % CPB == CPB / 2) begin
                  b   = (k - 1) / CPB;
                  j   = b / FB;
                  pos = b % FB;
                  if (j == 0 && pos >= 1 && pos <= 8) rx_hi[pos-1] = serial;
                  if (j == 1 && pos >= 1 && pos <= 8) rx_lo[pos-1] = serial;
               end
            end else begin
               chk("done_pulse", {31'd0, done}, 32'd1);
               chk("active_at_done", {31'd0, active}, 32'd0);
               chk("ready_at_done", {31'd0, ready}, 32'd0);
               chk("line_at_done", {31'd0, serial}, 32'd1);
               chk("rx_word", {16'd0, rx_hi, rx_lo}, {16'd0, cur.w});
               last_done_cyc = cyc;
               busy = 1'b0;
            end
         end else begin
            chk("idle_line", {31'd0, serial}, 32'd1);
            chk("idle_ready", {31'd0, ready}, 32'd1);
            chk("idle_active", {31'd0, active}, 32'd0);
            chk("idle_done", {31'd0, done}, 32'd0);
         end
      end
   end

   // Wait for ready, present the word for one edge, record the expected transmission
   task automatic send_word(input logic [15:0] w);
      int t;
      t = 0;
      @(negedge clk);
      while (!ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
         return;
      end
      dv   = 1'b1;
      word = w;
      last_acc = cyc + 1;
      exp_q.push_back('{w: w, acc: cyc + 1});
      @(negedge clk);
      dv   = 1'b0;
      word = 16'($urandom);
   endtask

   // One-cycle DV pulse while a word is in flight; must be ignored
   task automatic busy_pulse(input logic [15:0] w);
      @(negedge clk);
      dv   = 1'b1;
      word = w;
      @(negedge clk);
      dv   = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || exp_q.size() != 0) && t < 5000) begin
         @(negedge clk);
         t++;
      end
      if (busy || exp_q.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst  = 1'b1;
      dv   = 1'b0;
      word = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_line", {31'd0, serial}, 32'd1);
      chk("reset_ready", {31'd0, ready}, 32'd1);
      chk("reset_active", {31'd0, active}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      rst = 1'b0;
      repeat (50) @(negedge clk);

      // Single word with the documented Done cycle
      send_word(16'h1234);
      wait_idle();
      chk("done_cycle_1234", 32'(last_done_cyc - last_acc + 1), 32'(DONE_K));

      // Back-to-back: second start bit two cycles after the first Done
      send_word(16'h8001);
      send_word(16'h7FFE);
      chk("b2b_gap", 32'(last_acc - last_done_cyc), 32'd2);
      wait_idle();

      // Busy rejection mid-frame
      send_word(16'h5A3C);
      repeat (20) @(negedge clk);
      busy_pulse(16'hFFFF);
      wait_idle();

      // Asynchronous reset during the high byte's data bits
      send_word(16'h0000);
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_line", {31'd0, serial}, 32'd1);
      chk("async_rst_ready", {31'd0, ready}, 32'd1);
      chk("async_rst_active", {31'd0, active}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      send_word(16'h00FF);
      wait_idle();

`ifdef UART_TX_WORD_GAP_EN
      send_word(16'h0102);
      wait_idle();
      chk("wgap_done_cycle", 32'(last_done_cyc - last_acc + 1), 32'd169);
`endif

      // Random words, random idle spacing, occasional busy DV pulses
      for (int i = 0; i < 10; i++) begin
         send_word(16'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(2, 60)) @(negedge clk);
            busy_pulse(16'($urandom));
         end
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      wait_idle();
      repeat (20) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
